// File: rtl/alu_pkg.sv
// Shared opcode constants, opcode class decode and sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] OP_IINC = 4'd0;
  localparam logic [3:0] OP_IADD = 4'd1;
  localparam logic [3:0] OP_ISUB = 4'd2;
  localparam logic [3:0] OP_IMUL = 4'd3;
  localparam logic [3:0] OP_IDIV = 4'd4;
  localparam logic [3:0] OP_IREM = 4'd5;
  localparam logic [3:0] OP_IAND = 4'd6;
  localparam logic [3:0] OP_IOR  = 4'd7;
  localparam logic [3:0] OP_IXOR = 4'd8;
  localparam logic [3:0] OP_INEG = 4'd9;
  localparam logic [3:0] OP_ISHL = 4'd10;
  localparam logic [3:0] OP_ISHR = 4'd11;
  // Parked ALU select used whenever no operation is executing.
  localparam logic [3:0] OP_NONE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_POP_B, S_POP_A, S_EXEC, S_PUSH, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    CLS_BIN, CLS_UN, CLS_UNSUP
  } op_class_t;

  function automatic op_class_t op_class(input logic [3:0] op);
    case (op)
      OP_IADD, OP_ISUB, OP_IAND, OP_IOR, OP_IXOR: op_class = CLS_BIN;
      OP_IINC, OP_INEG, OP_ISHL, OP_ISHR:         op_class = CLS_UN;
      default:                                    op_class = CLS_UNSUP;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Operand-stack sequencer: pops operands, presents them to an external ALU,
// pushes the result back. Unsupported opcodes and stack underflow abort.
import alu_pkg::*;

module alu_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [3:0]        op_code,
  output logic              op_ready,
  input  logic [DATA_W-1:0] stack_top,
  input  logic              stack_empty,
  output logic              stack_pop,
  output logic              stack_push,
  output logic [DATA_W-1:0] stack_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              err
);

  state_t            r_state, w_next;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a, r_b, r_res;
  logic              w_accept;

  assign w_accept    = op_valid && (r_state == S_IDLE);
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign stack_wdata = r_res;

  // State register plus opcode/operand/result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_op <= op_code;
      if (r_state == S_POP_B && !stack_empty) r_b <= stack_top;
      if (r_state == S_POP_A && !stack_empty) begin
        r_a <= stack_top;
        // Unary ops present a clean zero on the second operand.
        if (op_class(r_op) == CLS_UN) r_b <= '0;
      end
      if (r_state == S_EXEC) r_res <= alu_result;
    end
  end

  // Next-state and strobe decode; pops are suppressed on an empty stack.
  always_comb begin
    w_next     = r_state;
    op_ready   = 1'b0;
    stack_pop  = 1'b0;
    stack_push = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    alu_op     = OP_NONE;
    case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          case (op_class(op_code))
            CLS_BIN: w_next = S_POP_B;
            CLS_UN:  w_next = S_POP_A;
            default: w_next = S_ERR;
          endcase
        end
      end
      S_POP_B: begin
        if (stack_empty) w_next = S_ERR;
        else begin
          stack_pop = 1'b1;
          w_next    = S_POP_A;
        end
      end
      S_POP_A: begin
        if (stack_empty) w_next = S_ERR;
        else begin
          stack_pop = 1'b1;
          w_next    = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op = r_op;
        w_next = S_PUSH;
      end
      S_PUSH: begin
        stack_push = 1'b1;
        done       = 1'b1;
        w_next     = S_IDLE;
      end
      S_ERR: begin
        err    = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
